// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall vectors, FSM encodings and legacy macros
// for the pipeline sequencing controller (pipe_ctrl).
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define RstEnable 1'b1
`define Branch    1'b1
`define RegBus    31:0
`endif

package pipe_ctrl_pkg;

    // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Later stages win: a stall freezes its own stage and everything upstream.
    function automatic logic [5:0] stall_vec(
        input logic i_if,
        input logic i_id,
        input logic i_ex
    );
        logic [5:0] v;
        if (i_ex)      v = STALL_EX;
        else if (i_id) v = STALL_ID;
        else if (i_if) v = STALL_IF;
        else           v = STALL_NONE;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// pipe_ctrl_stall_watchdog: saturating count of consecutive PC-stall cycles
// with a sticky flag. Ports: clk, rst, i_stall, o_timeout.
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            if (!i_stall)
                r_cnt <= '0;
            else if (r_cnt != LIMIT)
                r_cnt <= r_cnt + 1'b1;
            // Set on the edge where the count reaches the limit.
            if (i_stall && (r_cnt == LIMIT - 1'b1))
                r_flag <= 1'b1;
        end
    end

    assign o_timeout = r_flag;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, held-branch replay, exception flush sequencing.
// Ports: clk, rst, stallreq_{if,id,ex}_i, branch_*, flush_*, stall_o,
// branch_*_o, flush_o, stall_timeout_o. Macro PIPE_CTRL_PERF_EN adds
// stall_cycles_o and redirect_cnt_o.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallreq_if_i,
    input  logic           stallreq_id_i,
    input  logic           stallreq_ex_i,
    input  logic           branch_flag_i,
    input  logic [`RegBus] branch_target_address_i,
    input  logic           flush_req_i,
    input  logic [`RegBus] flush_pc_i,
    output logic [5:0]     stall_o,
    output logic           branch_flag_o,
    output logic [`RegBus] branch_target_address_o,
    output logic           flush_o,
    output logic           stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]    stall_cycles_o,
    output logic [31:0]    redirect_cnt_o
`endif
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [`RegBus] r_pend;
    logic [`RegBus] w_pend_nxt;
    logic [`RegBus] r_flush_pc;
    logic           w_pc_stall;
    logic           w_bf;
    logic [`RegBus] w_addr;
    logic           w_flush;

    // Pipeline registers are being cleared, so nothing may hold them.
    assign stall_o = (r_state == FLUSH) ? STALL_NONE :
                     stall_vec(stallreq_if_i, stallreq_id_i, stallreq_ex_i);
    assign w_pc_stall = stall_o[0];

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            r_state    <= RUN;
            r_pend     <= '0;
            r_flush_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (flush_req_i)
                r_flush_pc <= flush_pc_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_bf        = 1'b0;
        w_addr      = '0;
        w_flush     = 1'b0;
        unique case (r_state)
            RUN: begin
                if (flush_req_i) begin
                    w_state_nxt = FLUSH;
                    w_pend_nxt  = '0;
                end else if (branch_flag_i == `Branch) begin
                    if (w_pc_stall) begin
                        w_pend_nxt  = branch_target_address_i;
                        w_state_nxt = HOLD;
                    end else begin
                        w_bf   = 1'b1;
                        w_addr = branch_target_address_i;
                    end
                end
            end
            HOLD: begin
                if (flush_req_i) begin
                    w_state_nxt = FLUSH;
                    w_pend_nxt  = '0;
                end else if (w_pc_stall) begin
                    if (branch_flag_i == `Branch)
                        w_pend_nxt = branch_target_address_i;
                end else begin
                    // A fresh branch in the release cycle is newer.
                    w_bf        = 1'b1;
                    w_addr      = (branch_flag_i == `Branch) ?
                                  branch_target_address_i : r_pend;
                    w_pend_nxt  = '0;
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                w_flush     = 1'b1;
                w_bf        = 1'b1;
                w_addr      = r_flush_pc;
                w_pend_nxt  = '0;
                w_state_nxt = flush_req_i ? FLUSH : RUN;
            end
            default: begin
                w_state_nxt = RUN;
                w_pend_nxt  = '0;
            end
        endcase
    end

    assign branch_flag_o           = w_bf;
    assign branch_target_address_o = w_addr;
    assign flush_o                 = w_flush;

    pipe_ctrl_stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_stall_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (w_pc_stall),
        .o_timeout (stall_timeout_o)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            r_stall_cycles <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_pc_stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_bf)
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign redirect_cnt_o = r_redirect_cnt;
`endif

endmodule
